hazard_scheduler: RTL

//  Sequences the 5-stage pipeline around the instruction decoder: tracks in-flight destination regs in EX/MEM/WB,

---
 rtl/hazard_scheduler_pkg.sv | 38 +++
 rtl/hazard_scheduler_if.sv | 28 ++
 rtl/hazard_fwd_unit.sv | 19 +
 rtl/hazard_scheduler.sv | 109 ++++++++++
 4 files changed

// File: rtl/hazard_scheduler_pkg.sv
// hazard_scheduler_pkg: shared decode indices, forwarding codes, FSM states and slot types
package hazard_scheduler_pkg;
    localparam int ITYPE_R     = 8;
    localparam int ITYPE_IALU  = 7;
    localparam int ITYPE_LOAD  = 6;
    localparam int ITYPE_STORE = 5;
    localparam int ITYPE_BR    = 4;
    localparam int ITYPE_JAL   = 3;
    localparam int ITYPE_LUI   = 2;
    localparam int ITYPE_AUIPC = 1;
    localparam int ITYPE_JALR  = 0;

    localparam logic [8:0] USE1_MASK = (9'd1 << ITYPE_R) | (9'd1 << ITYPE_IALU) | (9'd1 << ITYPE_LOAD)
                                     | (9'd1 << ITYPE_STORE) | (9'd1 << ITYPE_BR) | (9'd1 << ITYPE_JALR);
    localparam logic [8:0] USE2_MASK = (9'd1 << ITYPE_R) | (9'd1 << ITYPE_STORE) | (9'd1 << ITYPE_BR);

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } slot_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
        logic       load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
    } ex_slot_t;
endpackage

// File: rtl/hazard_scheduler_if.sv
// hazard_scheduler_if: decoder-side inputs and pipeline-control outputs of the scheduler
interface hazard_scheduler_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic [4:0]       id_rd;
    logic [8:0]       id_type;
    logic             id_reg_en;
    logic             ex_redirect;
    logic             mem_busy;
    logic             stall_if_id;
    logic             freeze_all;
    logic             flush_if_id;
    logic             flush_ex;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_type, id_reg_en, ex_redirect, mem_busy,
        input  stall_if_id, freeze_all, flush_if_id, flush_ex, fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_type, id_reg_en, ex_redirect, mem_busy,
        output stall_if_id, freeze_all, flush_if_id, flush_ex, fwd_a_sel, fwd_b_sel, stall_count, flush_count
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: forwarding select for one EX operand, MEM result preferred over WB
module hazard_fwd_unit
    import hazard_scheduler_pkg::*;
(
    input  logic [4:0] i_rs,
    input  logic       i_use,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_wr,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_wr,
    output logic [1:0] o_sel
);
    logic w_mem_hit;
    logic w_wb_hit;

    assign w_mem_hit = i_use & i_mem_wr & (i_mem_rd != 5'd0) & (i_mem_rd == i_rs);
    assign w_wb_hit  = i_use & i_wb_wr & (i_wb_rd != 5'd0) & (i_wb_rd == i_rs);
    assign o_sel     = w_mem_hit ? FWD_EXMEM : w_wb_hit ? FWD_MEMWB : FWD_RF;
endmodule

// File: rtl/hazard_scheduler.sv
// hazard_scheduler: load-use stall, redirect flush, memory freeze and EX forwarding control
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    hazard_scheduler_if.slave bus
);
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t           r_state;
    logic [2:0]       r_cnt;
    ex_slot_t         r_ex;
    slot_t            r_mem;
    slot_t            r_wb;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    logic w_freeze;
    logic w_use1;
    logic w_use2;
    logic w_load_use;
    logic w_stall;
    logic w_redirect;
    logic w_bubble;

    assign w_freeze   = bus.mem_busy;
    assign w_use1     = |(bus.id_type & USE1_MASK);
    assign w_use2     = |(bus.id_type & USE2_MASK);
    assign w_load_use = r_ex.load & (r_ex.rd != 5'd0) & bus.id_valid
                      & ((w_use1 & (r_ex.rd == bus.id_rs1)) | (w_use2 & (r_ex.rd == bus.id_rs2)));
    assign w_redirect = bus.ex_redirect & ~w_freeze;
    assign w_stall    = w_load_use & ~w_freeze & ~bus.ex_redirect;
    assign w_bubble   = w_redirect | w_stall | ~bus.id_valid;

    assign bus.freeze_all  = w_freeze;
    assign bus.stall_if_id = w_stall;
    assign bus.flush_ex    = w_redirect;
    assign bus.flush_if_id = ~w_freeze & (bus.ex_redirect | (r_state == ST_FLUSH));
    assign bus.stall_count = r_stall_count;
    assign bus.flush_count = r_flush_count;

    hazard_fwd_unit u_fwd_a (
        .i_rs    (r_ex.rs1),
        .i_use   (r_ex.use1),
        .i_mem_rd(r_mem.rd),
        .i_mem_wr(r_mem.wr),
        .i_wb_rd (r_wb.rd),
        .i_wb_wr (r_wb.wr),
        .o_sel   (bus.fwd_a_sel)
    );

    hazard_fwd_unit u_fwd_b (
        .i_rs    (r_ex.rs2),
        .i_use   (r_ex.use2),
        .i_mem_rd(r_mem.rd),
        .i_mem_wr(r_mem.wr),
        .i_wb_rd (r_wb.rd),
        .i_wb_wr (r_wb.wr),
        .o_sel   (bus.fwd_b_sel)
    );

    // Advance the EX/MEM/WB tracking slots, inserting a bubble on flush, stall or empty ID
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ex  <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else if (!w_freeze) begin
            r_wb  <= r_mem;
            r_mem <= '{rd: r_ex.rd, wr: r_ex.wr, load: r_ex.load};
            r_ex  <= w_bubble ? '0 : '{rd: bus.id_rd, wr: bus.id_reg_en, load: bus.id_type[ITYPE_LOAD],
                                       rs1: bus.id_rs1, rs2: bus.id_rs2, use1: w_use1, use2: w_use2};
        end
    end

    // Flush FSM: r_cnt holds the FLUSH-state cycles still owed after the redirect cycle itself
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else if (!w_freeze) begin
            if (bus.ex_redirect) begin
                r_state <= (FLUSH_INIT != 3'd0) ? ST_FLUSH : ST_RUN;
                r_cnt   <= FLUSH_INIT;
            end else if (r_state == ST_FLUSH) begin
                r_state <= (r_cnt <= 3'd1) ? ST_RUN : ST_FLUSH;
                r_cnt   <= (r_cnt == 3'd0) ? 3'd0 : r_cnt - 3'd1;
            end
        end
    end

    // Saturating event counters for stall cycles and taken redirects
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall && r_stall_count != CNT_MAX)
                r_stall_count <= r_stall_count + 1'b1;
            if (w_redirect && r_flush_count != CNT_MAX)
                r_flush_count <= r_flush_count + 1'b1;
        end
    end
endmodule
